// File: rtl/snn_output_decoder.sv
// Spike-count output decoder: accumulates per-neuron spike counts over a window,
// then runs a sequential argmax. Optional early exit via SNN_DECODER_EARLY_EXIT_EN.
module snn_output_decoder #(
  parameter int NUM_OUTPUTS  = 2,
  parameter int CNT_WIDTH    = 16,
  parameter int WINDOW_WIDTH = 16,
  parameter int EARLY_THRESH = 8,
  localparam int IDX_WIDTH   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [WINDOW_WIDTH-1:0]          window_len,
  input  logic                             step_valid,
  input  logic [NUM_OUTPUTS-1:0]           spikes_in,
  output logic                             busy,
  output logic                             done,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic [IDX_WIDTH-1:0]             class_idx,
  output logic [CNT_WIDTH-1:0]             class_count,
  output logic                             tie,
  output logic [NUM_OUTPUTS*CNT_WIDTH-1:0] spike_counts
);

`ifdef SNN_DECODER_EARLY_EXIT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  localparam logic [CNT_WIDTH:0] THRESH = (CNT_WIDTH+1)'(EARLY_THRESH);

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, HOLD} state_t;

  state_t                  state;
  logic [CNT_WIDTH-1:0]    counts      [NUM_OUTPUTS];
  logic [CNT_WIDTH-1:0]    next_counts [NUM_OUTPUTS];
  logic [WINDOW_WIDTH-1:0] win_len;
  logic [WINDOW_WIDTH-1:0] step_cnt;
  logic [IDX_WIDTH-1:0]    ptr;
  logic                    thresh_hit;
  logic                    last_step;

  // Saturating increments and the early-exit test share the post-increment values.
  always_comb begin
    thresh_hit = 1'b0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      next_counts[i] = counts[i];
      if (spikes_in[i] && (counts[i] != '1))
        next_counts[i] = counts[i] + CNT_WIDTH'(1);
      if ({1'b0, next_counts[i]} >= THRESH)
        thresh_hit = 1'b1;
    end
  end

  assign last_step = (step_cnt == (win_len - WINDOW_WIDTH'(1))) || (EARLY_EN && thresh_hit);

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_flat
    assign spike_counts[g*CNT_WIDTH +: CNT_WIDTH] = counts[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counts       <= '{default: '0};
      win_len      <= '0;
      step_cnt     <= '0;
      ptr          <= '0;
      class_idx    <= '0;
      class_count  <= '0;
      tie          <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            win_len     <= window_len;
            step_cnt    <= '0;
            ptr         <= '0;
            counts      <= '{default: '0};
            class_idx   <= '0;
            class_count <= '0;
            tie         <= 1'b0;
            busy        <= 1'b1;
            state       <= (window_len == '0) ? SCAN : ACCUM;
          end
        end
        ACCUM: begin
          if (step_valid) begin
            counts   <= next_counts;
            step_cnt <= step_cnt + WINDOW_WIDTH'(1);
            if (last_step)
              state <= SCAN;
          end
        end
        SCAN: begin
          // Strict greater-than keeps the lowest index on equal counts.
          if (ptr == '0) begin
            class_count <= counts[0];
            class_idx   <= '0;
            tie         <= 1'b0;
          end else if (counts[ptr] > class_count) begin
            class_count <= counts[ptr];
            class_idx   <= ptr;
            tie         <= 1'b0;
          end else if (counts[ptr] == class_count) begin
            tie <= 1'b1;
          end
          if (ptr == IDX_WIDTH'(NUM_OUTPUTS - 1)) begin
            ptr          <= '0;
            state        <= HOLD;
            done         <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end else begin
            ptr <= ptr + IDX_WIDTH'(1);
          end
        end
        HOLD: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_output_decoder.sv
// Self-checking bench for snn_output_decoder: directed windows plus random windows
// checked against a count-and-argmax model.
module tb_snn_output_decoder;

  localparam int NO   = 3;
  localparam int CW   = 4;
  localparam int WW   = 8;
  localparam int ET   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WW-1:0] window_len;
  logic          step_valid;
  logic [NO-1:0] spikes_in;
  logic          busy;
  logic          done;
  logic          result_valid;
  logic          result_ready;
  logic [1:0]    class_idx;
  logic [CW-1:0] class_count;
  logic          tie;
  logic [NO*CW-1:0] spike_counts;

  int checks = 0;
  int errors = 0;
  int mcounts [NO];
  logic [NO-1:0] pattern [$];

  snn_output_decoder #(
    .NUM_OUTPUTS(NO), .CNT_WIDTH(CW), .WINDOW_WIDTH(WW), .EARLY_THRESH(ET)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .window_len(window_len),
    .step_valid(step_valid), .spikes_in(spikes_in), .busy(busy), .done(done),
    .result_valid(result_valid), .result_ready(result_ready),
    .class_idx(class_idx), .class_count(class_count), .tie(tie),
    .spike_counts(spike_counts)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] packCounts();
    logic [31:0] r = '0;
    for (int i = 0; i < NO; i++) r[i*CW +: CW] = CW'(mcounts[i]);
    return r;
  endfunction

  function automatic int winnerIdx();
    int best = 0;
    for (int i = 1; i < NO; i++) if (mcounts[i] > mcounts[best]) best = i;
    return best;
  endfunction

  function automatic int numAtMax();
    int n = 0;
    for (int i = 0; i < NO; i++) if (mcounts[i] == mcounts[winnerIdx()]) n++;
    return n;
  endfunction

  task automatic fillConst(input int n, input logic [NO-1:0] v);
    pattern.delete();
    repeat (n) pattern.push_back(v);
  endtask

  task automatic fillRandom(input int n);
    pattern.delete();
    repeat (n) pattern.push_back(NO'($urandom));
  endtask

  // Runs one window from IDLE and keeps the reference counts in step with it.
  task automatic applyStimulus(input int wlen, input int gap_max, input bit poke);
    int  steps = 0;
    int  k = 0;
    bit  fin;
    bit  do_poke = poke;
    step_valid = 1'b1;
    spikes_in  = '1;
    @(negedge clk);
    start      = 1'b1;
    window_len = WW'(wlen);
    @(negedge clk);
    start      = 1'b0;
    step_valid = 1'b0;
    for (int i = 0; i < NO; i++) mcounts[i] = 0;
    fin = (wlen == 0);
    while (!fin && k < pattern.size()) begin
      repeat ($urandom_range(0, gap_max)) begin
        step_valid = 1'b0;
        spikes_in  = NO'($urandom);
        @(negedge clk);
      end
      if (do_poke && steps == wlen / 2) begin
        start      = 1'b1;
        window_len = WW'(1);
        step_valid = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        do_poke = 1'b0;
      end
      step_valid = 1'b1;
      spikes_in  = pattern[k];
      for (int i = 0; i < NO; i++)
        if (pattern[k][i] && mcounts[i] < MAXC) mcounts[i]++;
      k++;
      steps++;
      fin = (steps == wlen);
`ifdef SNN_DECODER_EARLY_EXIT_EN
      for (int i = 0; i < NO; i++) if (mcounts[i] >= ET) fin = 1'b1;
`endif
      @(negedge clk);
      checkOutput("live_counts", 32'(spike_counts), packCounts());
    end
    step_valid = 1'b0;
    spikes_in  = '0;
    checkOutput("busy_after_window", 32'(busy), 32'd1);
  endtask

  task automatic waitResult(input string tag);
    int lat = 0;
    while (result_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    $display("[TB] %s: result after %0d scan cycles", tag, lat);
    checkOutput("scan_latency", lat, NO);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_in_hold", 32'(busy), 32'd0);
    checkOutput("class_idx", 32'(class_idx), winnerIdx());
    checkOutput("class_count", 32'(class_count), mcounts[winnerIdx()]);
    checkOutput("tie", 32'(tie), 32'(numAtMax() > 1));
    checkOutput("final_counts", 32'(spike_counts), packCounts());
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("valid_held", 32'(result_valid), 32'd1);
    start      = 1'b1;
    window_len = WW'(5);
    @(negedge clk);
    start = 1'b0;
    checkOutput("hold_start_ignored_valid", 32'(result_valid), 32'd1);
    checkOutput("hold_start_ignored_idx", 32'(class_idx), winnerIdx());
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput("valid_dropped", 32'(result_valid), 32'd0);
    checkOutput("idle_not_busy", 32'(busy), 32'd0);
    checkOutput("count_kept_after_hold", 32'(class_count), mcounts[winnerIdx()]);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; window_len = '0; step_valid = 1'b0;
    spikes_in = '0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(result_valid), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_class", 32'({class_idx, class_count, tie}), 32'd0);
    checkOutput("rst_counts", 32'(spike_counts), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: neuron 1 wins 6 to 2
    pattern.delete();
    repeat (6) pattern.push_back(3'b010);
    repeat (2) pattern.push_back(3'b001);
    repeat (2) pattern.push_back(3'b000);
    applyStimulus(10, 0, 1'b0);
    waitResult("t1_clear_winner");

    // Test 2: equal counts, lowest index wins with tie
    fillConst(4, 3'b011);
    applyStimulus(4, 1, 1'b1);
    waitResult("t2_tie");

    // Test 3: empty window goes straight to scan
    pattern.delete();
    applyStimulus(0, 0, 1'b0);
    waitResult("t3_empty_window");

    // Test 4: saturation at all-ones
    fillConst(20, 3'b001);
    applyStimulus(20, 0, 1'b0);
    waitResult("t4_saturate");

    // Test 5: reset mid-window aborts everything
    start = 1'b1; window_len = WW'(10);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      step_valid = 1'b1; spikes_in = 3'b101;
      @(negedge clk);
    end
    step_valid = 1'b0; spikes_in = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_valid", 32'(result_valid), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_class", 32'({class_idx, class_count, tie}), 32'd0);
    checkOutput("midrst_counts", 32'(spike_counts), 32'd0);
    fillConst(2, 3'b100);
    applyStimulus(2, 1, 1'b0);
    waitResult("t5_after_reset");

    // Test 6: neuron 1 spikes every step (early exit only if enabled)
    fillConst(10, 3'b010);
    applyStimulus(10, 0, 1'b0);
    waitResult("t6_early_exit");

    // Random windows
    for (int n = 0; n < 12; n++) begin
      int wl = $urandom_range(0, 12);
      fillRandom(wl);
      applyStimulus(wl, 2, 1'($urandom));
      waitResult("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_output_decoder.md
Name: snn_output_decoder

Overview:
- Consumes output-layer spikes from snn_core_top, one vector per timestep.
- Accumulates per-neuron spike counts over a programmable window of timesteps, then picks the winning class with a sequential argmax.
- Holds the result behind a valid/ready handshake for the AXI config-register block to read.

Parameters:
NUM_OUTPUTS, 2, number of output neurons (>=1)
CNT_WIDTH, 16, width of each spike counter
WINDOW_WIDTH, 16, width of window length and step counter
EARLY_THRESH, 8, early-exit count; used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse; begins a window (accepted only in IDLE)
window_len  in  WINDOW_WIDTH  timesteps per window, sampled when start is accepted
step_valid  in  1  one timestep of spikes_in is presented this cycle
spikes_in  in  NUM_OUTPUTS  output spike vector for the current timestep
busy  out  1  high in ACCUM and SCAN
done  out  1  one-cycle pulse on the SCAN->HOLD transition
result_valid  out  1  result held; high in HOLD
result_ready  in  1  consumer accepts result
class_idx  out  max(1,$clog2(NUM_OUTPUTS))  winning neuron index
class_count  out  CNT_WIDTH  spike count of the winner
tie  out  1  another neuron equals the winning count
spike_counts  out  NUM_OUTPUTS*CNT_WIDTH  all counters; neuron i at bits [i*CNT_WIDTH +: CNT_WIDTH]

Behaviour:
- Reset (rst high at a clk edge): state IDLE; all counters, step counter, class_idx, class_count, tie, done, busy and result_valid are 0. Reset mid-window or mid-HOLD aborts and discards the result.
- FSM states: IDLE, ACCUM, SCAN, HOLD.
- IDLE:
  - On start, latch window_len, clear all counters and the step counter.
  - If window_len==0, go to SCAN; otherwise go to ACCUM.
  - step_valid is ignored in IDLE.
- ACCUM:
  - On each cycle with step_valid, increment counter i for every set bit spikes_in[i]. Counters saturate at all-ones and never wrap.
  - On the same edge, the step counter increments.
  - When step_valid arrives with step counter == window_len-1, that step is still counted and the next state is SCAN.
  - Cycles without step_valid change nothing.
- SCAN: lasts exactly NUM_OUTPUTS cycles, pointer p = 0..NUM_OUTPUTS-1.
  - p=0: load max=count[0], idx=0, tie=0.
  - p>0, count[p] > max: max=count[p], idx=p, tie=0.
  - p>0, count[p] == max: tie=1; idx is unchanged, so the lowest index wins.
  - After p=NUM_OUTPUTS-1, go to HOLD and pulse done for one cycle.
- HOLD:
  - result_valid=1; class_idx, class_count, tie and spike_counts are stable.
  - When result_valid && result_ready at a clk edge, go to IDLE. result_valid drops the next cycle; outputs keep their values until the next start.
  - start in HOLD is ignored.
- start outside IDLE is ignored, with no effect on state or counters.
- Latency: window_len step cycles, then NUM_OUTPUTS SCAN cycles, then result_valid. If result_ready is already high, HOLD lasts 1 cycle.
- window_len==0: all counters stay 0; result is class 0, count 0, tie=1 if NUM_OUTPUTS>1.
- spike_counts is live during ACCUM and frozen from SCAN onward.

Optional Feature:
- Macro: SNN_DECODER_EARLY_EXIT_EN.
- Defined: in ACCUM, if any counter's post-increment value >= EARLY_THRESH on a step_valid cycle, go to SCAN after that step even if the window is not finished. The step is counted.
- Not defined: the window always runs its full window_len steps, and EARLY_THRESH is unused.

Test Plan:
1. NUM_OUTPUTS=2, window_len=10, start; 10 steps with spikes_in=2'b10 on steps 0-5 and 2'b01 on steps 6-7 -> counts {1:6, 0:2}; done pulses 2 cycles after the last step; class_idx=1, class_count=6, tie=0.
2. window_len=4, 4 steps of spikes_in=2'b11 -> counts 4/4; class_idx=0, class_count=4, tie=1.
3. window_len=0, start -> SCAN entered directly; result class 0, count 0, tie=1. start pulsed during HOLD is ignored; result_ready=1 -> back to IDLE.
4. CNT_WIDTH=4, window_len=20, neuron 0 spikes every step -> count saturates at 15 and does not wrap; class_idx=0, class_count=15.
5. rst asserted after 3 of 10 steps -> next cycle all outputs are 0 and the state is IDLE; a new start with window_len=2 completes normally.
6. With SNN_DECODER_EARLY_EXIT_EN, EARLY_THRESH=3, window_len=10, neuron 1 spikes every step -> SCAN entered after step 3; class_idx=1, class_count=3. Without the macro, the full 10 steps run and class_count=10.
